mem_arbiter: RTL and testbench

- Shares one physical memory port between the instruction-side and data-side cache miss paths of the pipelined LC-3b CPU.
- Sits between the I-cache/D-cache line-fill interfaces and physical memory.
- Grants one requester at a time and holds the grant until memory responds. Alternating priority prevents starvation when both requesters are waiting.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_control.sv | 68 ++++++
 rtl/mux2.sv | 19 +
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the I/D memory arbiter
//
// Provides the cache line type, the arbiter state encoding and the side
// identifier used for the grant history and the output select.
package mem_arbiter_pkg;

    localparam int LC3B_LINE_W = 128;
    localparam int LC3B_ADDR_W = 16;

    typedef logic [LC3B_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

endpackage

// File: rtl/mem_arbiter_control.sv
// rtl/mem_arbiter_control.sv - grant FSM and alternating-priority history
//
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   i_req      : I-side requesting (read or write)
//   d_req      : D-side requesting (read or write)
//   pmem_resp  : physical memory completion, ends the current grant
//   state      : current arbiter state
//   sel        : side whose signals drive the memory port
module mem_arbiter_control
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       pmem_resp,
    output arb_state_t state,
    output arb_side_t  sel
);

    arb_state_t state_q, state_d;
    arb_side_t  last_grant_q, last_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= SIDE_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first,
                // so D wins the first tie after reset.
                if (i_req && d_req)
                    state_d = (last_grant_q == SIDE_I) ? SERVE_D : SERVE_I;
                else if (i_req)
                    state_d = SERVE_I;
                else if (d_req)
                    state_d = SERVE_D;
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = SIDE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = SIDE_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;
    assign sel   = (state_q == SERVE_D) ? SIDE_D : SIDE_I;

endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - parameterised two-input multiplexer
//
// Ports:
//   sel : 0 selects a, 1 selects b
//   a   : input 0
//   b   : input 1
//   y   : selected value
module mux2 #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one physical memory port between I and D line fills
//
// Ports:
//   clk, reset                         : system clock, synchronous active-high reset
//   i_read/i_write/i_address/i_wdata   : I-side level request and write line
//   i_resp/i_rdata                     : I-side one-cycle completion and read line
//   d_read/d_write/d_address/d_wdata   : D-side level request and write line
//   d_resp/d_rdata                     : D-side one-cycle completion and read line
//   pmem_read/pmem_write/pmem_address/pmem_wdata : physical memory request
//   pmem_resp/pmem_rdata               : physical memory completion and read line
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t        state;
    arb_side_t         sel;
    logic              sel_d;
    logic              serving;
    logic              read_mux;
    logic              write_mux;
    logic [ADDR_W-1:0] address_mux;
    logic [LINE_W-1:0] wdata_mux;

    mem_arbiter_control u_control (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_read | i_write),
        .d_req     (d_read | d_write),
        .pmem_resp (pmem_resp),
        .state     (state),
        .sel       (sel)
    );

    assign sel_d   = (sel == SIDE_D);
    assign serving = (state != IDLE);

    mux2 #(.W(1)) u_read_mux (
        .sel (sel_d),
        .a   (i_read),
        .b   (d_read),
        .y   (read_mux)
    );

    mux2 #(.W(1)) u_write_mux (
        .sel (sel_d),
        .a   (i_write),
        .b   (d_write),
        .y   (write_mux)
    );

    mux2 #(.W(ADDR_W)) u_address_mux (
        .sel (sel_d),
        .a   (i_address),
        .b   (d_address),
        .y   (address_mux)
    );

    mux2 #(.W(LINE_W)) u_wdata_mux (
        .sel (sel_d),
        .a   (i_wdata),
        .b   (d_wdata),
        .y   (wdata_mux)
    );

    // The whole memory-side bundle is forced to zero while idle so memory
    // never sees a stale address or line between grants.
    assign pmem_read    = serving & read_mux;
    assign pmem_write   = serving & write_mux;
    assign pmem_address = {ADDR_W{serving}} & address_mux;
    assign pmem_wdata   = {LINE_W{serving}} & wdata_mux;

    // Responses are routed only to the granted side; a pmem_resp seen while
    // idle reaches neither requester.
    assign i_resp  = (state == SERVE_I) & pmem_resp;
    assign d_resp  = (state == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    a_i_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(i_read && i_write));
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 16;

    localparam logic [LINE_W-1:0] W1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [LINE_W-1:0] W2 = 128'hAAAA0000_BBBB0000_CCCC0000_DDDD0000;
    localparam logic [LINE_W-1:0] W3 = 128'hDEADBEEF_00C0FFEE_13579BDF_2468ACE0;
    localparam logic [LINE_W-1:0] W4 = 128'h01234567_89ABCDEF_FEDCBA98_765489AB;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read, i_write, d_read, d_write;
    logic [ADDR_W-1:0] i_address, d_address;
    logic [LINE_W-1:0] i_wdata, d_wdata;
    logic              i_resp, d_resp;
    logic [LINE_W-1:0] i_rdata, d_rdata;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;

    mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_address    (i_address),
        .i_wdata      (i_wdata),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                side_d;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                lat;
    } exp_t;

    exp_t sb[$];
    int   total      = 0;
    int   passed     = 0;
    int   resp_count = 0;
    int   mem_lat    = 4;

    function automatic logic [LINE_W-1:0] rdata_of(input logic [ADDR_W-1:0] a);
        return {a, 96'h5A5A5A5A_A5A5A5A5_3C3C3C3C, 16'hCAFE};
    endfunction

    function automatic exp_t mk(input bit side_d, input bit wr,
                                input logic [ADDR_W-1:0] addr,
                                input logic [LINE_W-1:0] wdata, input int lat);
        exp_t e;
        e.side_d = side_d;
        e.wr     = wr;
        e.addr   = addr;
        e.wdata  = wdata;
        e.lat    = lat;
        return e;
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int n);
        int target;
        int cyc;
        target = resp_count + n;
        cyc    = 0;
        while (resp_count < target && cyc < 300) begin
            step();
            cyc++;
        end
        if (resp_count < target) begin
            total++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", resp_count, target);
        end
    endtask

    // Physical memory model: answers after mem_lat strobe cycles.
    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            pmem_resp = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = rdata_of(pmem_address);
                    cnt        = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every response.
    initial begin
        int   scnt;
        bit   prev_resp;
        exp_t e;
        scnt      = 0;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                scnt      = 0;
                prev_resp = 1'b0;
            end else begin
                if (prev_resp)
                    chk("idle_bubble", {126'd0, pmem_read, pmem_write}, '0);
                if (pmem_read || pmem_write)
                    scnt++;
                prev_resp = i_resp | d_resp;
                if (i_resp || d_resp) begin
                    chk("single_resp", i_resp & d_resp, '0);
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none",
                                 i_resp, d_resp);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_side", d_resp, e.side_d);
                        chk("pmem_address", pmem_address, e.addr);
                        chk("pmem_read", pmem_read, !e.wr);
                        chk("pmem_write", pmem_write, e.wr);
                        chk("pmem_wdata", pmem_wdata, e.wdata);
                        chk("strobe_cycles", scnt, e.lat);
                        if (!e.wr)
                            chk("rdata", e.side_d ? d_rdata : i_rdata, rdata_of(e.addr));
                    end
                    resp_count++;
                    scnt = 0;
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        i_read    = 1'b0;
        i_write   = 1'b0;
        i_address = '0;
        i_wdata   = '0;
        d_read    = 1'b1;
        d_write   = 1'b0;
        d_address = 16'h0100;
        d_wdata   = W1;
        mem_lat   = 4;

        // Reset with a pending D request: memory port stays quiet.
        sb.push_back(mk(1'b1, 1'b0, 16'h0100, W1, 4));
        repeat (2) begin
            @(negedge clk);
            chk("rst_pmem_read", pmem_read, '0);
            chk("rst_pmem_write", pmem_write, '0);
            chk("rst_pmem_address", pmem_address, '0);
            chk("rst_resp", {i_resp, d_resp}, '0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("first_grant_read", pmem_read, 1'b1);
        chk("first_grant_address", pmem_address, 16'h0100);
        wait_resp(1);
        d_read = 1'b0;

        // Single I read, four-cycle memory.
        i_read    = 1'b1;
        i_address = 16'h0060;
        i_wdata   = W2;
        sb.push_back(mk(1'b0, 1'b0, 16'h0060, W2, 4));
        wait_resp(1);
        i_read = 1'b0;

        // Tie after reset then continuous alternation: D, I, D, I, D, I.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        mem_lat   = 2;
        i_read    = 1'b1;
        i_address = 16'h0200;
        d_read    = 1'b1;
        d_address = 16'h1000;
        d_wdata   = W1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(1'b1, 1'b0, 16'h1000, W1, 2));
            sb.push_back(mk(1'b0, 1'b0, 16'h0200, W2, 2));
        end
        wait_resp(6);
        i_read = 1'b0;
        d_read = 1'b0;

        // I write with single-cycle memory.
        mem_lat   = 1;
        i_write   = 1'b1;
        i_address = 16'h0300;
        i_wdata   = W3;
        sb.push_back(mk(1'b0, 1'b1, 16'h0300, W3, 1));
        wait_resp(1);
        i_write = 1'b0;

        // D writeback; leaves last_grant at D.
        mem_lat   = 3;
        d_write   = 1'b1;
        d_address = 16'h2040;
        d_wdata   = W4;
        sb.push_back(mk(1'b1, 1'b1, 16'h2040, W4, 3));
        wait_resp(1);
        d_write = 1'b0;

        // Reset two cycles into SERVE_I drops the transaction.
        mem_lat   = 10;
        i_read    = 1'b1;
        i_address = 16'h0400;
        i_wdata   = W2;
        step();
        step();
        reset     = 1'b1;
        d_read    = 1'b1;
        d_address = 16'h1100;
        d_wdata   = W1;
        @(negedge clk);
        chk("pre_reset_read", pmem_read, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_read", pmem_read, '0);
        chk("mid_rst_address", pmem_address, '0);
        chk("mid_rst_resp", {i_resp, d_resp}, '0);
        reset   = 1'b0;
        mem_lat = 2;
        sb.push_back(mk(1'b1, 1'b0, 16'h1100, W1, 2));
        sb.push_back(mk(1'b0, 1'b0, 16'h0400, W2, 2));
        wait_resp(2);
        i_read = 1'b0;
        d_read = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), '0);
        chk("final_idle", {126'd0, pmem_read, pmem_write}, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
